// File: rtl/video_timing.sv
// video_timing -- raster timing generator for the tile and sprite pipeline.
//
// Produces the half-pixel horizontal counter, the raw and flip-adjusted
// vertical line counters, blanking and sync decodes, frame/vblank strobes
// and the latched CPU vertical-blank NMI request.
//
// Only four things are registered: htiming, vcount, flip_q and the NMI latch.
// Every other output is a combinational decode of those registers, so all
// outputs describe the same raster position with no extra latency.
//
// Ports:
//   clk         in   1  half-pixel clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   flip_ena    in   1  screen flip request, taken only at frame start
//   nmi_mask    in   1  NMI enable (1 = enabled); 0 also clears a pending NMI
//   nmi_ack     in   1  one-clk NMI acknowledge
//   htiming     out 10  horizontal counter 0..H_TOTAL-1, bit 9 = hblank
//   vcount      out  9  raw line counter 0..V_TOTAL-1
//   vtiming_f   out  8  vcount[7:0] inverted when flip_q is set
//   flip_q      out  1  frame-synchronised flip
//   hblank      out  1  horizontal blank (htiming[9])
//   vblank      out  1  line outside V_ACT_START..V_ACT_END-1
//   cmpblk      out  1  hblank | vblank
//   hsync_n     out  1  low for HS_START <= htiming < HS_END
//   vsync_n     out  1  low for VS_START <= vcount < VS_END
//   vblk_start  out  1  strobe at vcount == V_ACT_END, htiming == 0
//   frame_start out  1  strobe at vcount == 0, htiming == 0
//   nmi_n       out  1  level NMI request, active low
//
// Parameter legality: H_TOTAL even and within 514..1024, V_TOTAL <= 512.
// The active line is always htiming 0..511, so hblank is simply bit 9.

module video_timing #(
  parameter int H_TOTAL     = 768,
  parameter int V_TOTAL     = 264,
  parameter int V_ACT_START = 16,
  parameter int V_ACT_END   = 240,
  parameter int HS_START    = 576,
  parameter int HS_END      = 640,
  parameter int VS_START    = 244,
  parameter int VS_END      = 248
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flip_ena,
  input  logic       nmi_mask,
  input  logic       nmi_ack,
  output logic [9:0] htiming,
  output logic [8:0] vcount,
  output logic [7:0] vtiming_f,
  output logic       flip_q,
  output logic       hblank,
  output logic       vblank,
  output logic       cmpblk,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vblk_start,
  output logic       frame_start,
  output logic       nmi_n
);

  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST_C   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT_S_C  = 9'(V_ACT_START);
  localparam logic [8:0] V_ACT_E_C  = 9'(V_ACT_END);
  localparam logic [9:0] HS_S_C     = 10'(HS_START);
  localparam logic [9:0] HS_E_C     = 10'(HS_END);
  localparam logic [8:0] VS_S_C     = 9'(VS_START);
  localparam logic [8:0] VS_E_C     = 9'(VS_END);

  logic [9:0] htiming_r;
  logic [8:0] vcount_r;
  logic       flip_r;
  logic       nmi_pend_r;

  logic       h_wrap_s;
  logic       frame_wrap_s;
  logic       vblk_start_s;
  logic       frame_start_s;
  logic       vblank_s;
  logic       hsync_n_s;
  logic       vsync_n_s;

  // Wrap conditions of the raster; frame_wrap_s marks the edge entering line 0, pixel 0.
  always_comb begin
    h_wrap_s     = 1'b0;
    frame_wrap_s = 1'b0;
    if (htiming_r == H_LAST_C) begin
      h_wrap_s     = 1'b1;
      frame_wrap_s = (vcount_r == V_LAST_C);
    end else begin
      h_wrap_s     = 1'b0;
      frame_wrap_s = 1'b0;
    end
  end

  // Horizontal and vertical raster counters; vcount only moves on the line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      htiming_r <= 10'd0;
      vcount_r  <= 9'd0;
    end else if (h_wrap_s) begin
      htiming_r <= 10'd0;
      if (vcount_r == V_LAST_C) begin
        vcount_r <= 9'd0;
      end else begin
        vcount_r <= vcount_r + 9'd1;
      end
    end else begin
      htiming_r <= htiming_r + 10'd1;
    end
  end

  // Flip is sampled once per frame so a whole frame is drawn with one orientation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_r <= 1'b0;
    end else if (frame_wrap_s) begin
      flip_r <= flip_ena;
    end else begin
      flip_r <= flip_r;
    end
  end

  // NMI latch: clear (ack or mask off) wins over a coincident vblank set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_pend_r <= 1'b0;
    end else if (nmi_ack || !nmi_mask) begin
      nmi_pend_r <= 1'b0;
    end else if (vblk_start_s) begin
      nmi_pend_r <= 1'b1;
    end else begin
      nmi_pend_r <= nmi_pend_r;
    end
  end

  // Blank, sync and strobe decodes of the current raster position.
  always_comb begin
    vblank_s      = 1'b0;
    hsync_n_s     = 1'b1;
    vsync_n_s     = 1'b1;
    vblk_start_s  = 1'b0;
    frame_start_s = 1'b0;

    vblank_s = (vcount_r < V_ACT_S_C) || (vcount_r >= V_ACT_E_C);

    if ((htiming_r >= HS_S_C) && (htiming_r < HS_E_C)) begin
      hsync_n_s = 1'b0;
    end else begin
      hsync_n_s = 1'b1;
    end

    if ((vcount_r >= VS_S_C) && (vcount_r < VS_E_C)) begin
      vsync_n_s = 1'b0;
    end else begin
      vsync_n_s = 1'b1;
    end

    if (htiming_r == 10'd0) begin
      vblk_start_s  = (vcount_r == V_ACT_E_C);
      frame_start_s = (vcount_r == 9'd0);
    end else begin
      vblk_start_s  = 1'b0;
      frame_start_s = 1'b0;
    end
  end

  assign htiming     = htiming_r;
  assign vcount      = vcount_r;
  assign flip_q      = flip_r;
  assign vtiming_f   = vcount_r[7:0] ^ {8{flip_r}};
  assign hblank      = htiming_r[9];
  assign vblank      = vblank_s;
  assign cmpblk      = htiming_r[9] | vblank_s;
  assign hsync_n     = hsync_n_s;
  assign vsync_n     = vsync_n_s;
  assign vblk_start  = vblk_start_s;
  assign frame_start = frame_start_s;
  assign nmi_n       = ~nmi_pend_r;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing.
// The DUT is built with a shortened raster (520 x 16) so several whole frames
// fit in a short run. The reference model derives the raster position from an
// absolute clock count since reset (t mod H, t div H mod V) and evaluates the
// output rules directly from that position.

module tb_video_timing;

  localparam int H   = 520;
  localparam int V   = 16;
  localparam int VAS = 2;
  localparam int VAE = 12;
  localparam int HSS = 514;
  localparam int HSE = 518;
  localparam int VSS = 13;
  localparam int VSE = 15;
  localparam int FR  = H * V;   // 8320 clocks per frame

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flip_ena, nmi_mask, nmi_ack;
  logic [9:0] htiming;
  logic [8:0] vcount;
  logic [7:0] vtiming_f;
  logic       flip_q, hblank, vblank, cmpblk, hsync_n, vsync_n;
  logic       vblk_start, frame_start, nmi_n;

  int n_vec  = 0;
  int n_fail = 0;

  // model state
  int t      = 0;
  bit mflip  = 1'b0;
  bit mpend  = 1'b0;

  video_timing #(
    .H_TOTAL(H), .V_TOTAL(V), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flip_ena(flip_ena), .nmi_mask(nmi_mask),
    .nmi_ack(nmi_ack), .htiming(htiming), .vcount(vcount),
    .vtiming_f(vtiming_f), .flip_q(flip_q), .hblank(hblank),
    .vblank(vblank), .cmpblk(cmpblk), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .vblk_start(vblk_start), .frame_start(frame_start), .nmi_n(nmi_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  // Reference model: advance the absolute clock count, flip and NMI latch.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t     <= 0;
      mflip <= 1'b0;
      mpend <= 1'b0;
    end else begin
      if ((t % FR) == FR - 1) mflip <= flip_ena;
      if (nmi_ack || !nmi_mask) mpend <= 1'b0;
      else if (((t / H) % V) == VAE && (t % H) == 0) mpend <= 1'b1;
      t <= t + 1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    int h, v;
    h = t % H;
    v = (t / H) % V;
    check("htiming",     32'(htiming),     h);
    check("vcount",      32'(vcount),      v);
    check("vtiming_f",   32'(vtiming_f),   mflip ? (255 - (v % 256)) : (v % 256));
    check("flip_q",      32'(flip_q),      32'(mflip));
    check("hblank",      32'(hblank),      (h >= 512) ? 1 : 0);
    check("vblank",      32'(vblank),      (v < VAS || v >= VAE) ? 1 : 0);
    check("cmpblk",      32'(cmpblk),      (h >= 512 || v < VAS || v >= VAE) ? 1 : 0);
    check("hsync_n",     32'(hsync_n),     (h >= HSS && h < HSE) ? 0 : 1);
    check("vsync_n",     32'(vsync_n),     (v >= VSS && v < VSE) ? 0 : 1);
    check("vblk_start",  32'(vblk_start),  (v == VAE && h == 0) ? 1 : 0);
    check("frame_start", 32'(frame_start), (v == 0 && h == 0) ? 1 : 0);
    check("nmi_n",       32'(nmi_n),       mpend ? 0 : 1);
  end

  // Wait (on falling edges) until the model clock count reaches target.
  task automatic wait_to(input int target);
    int guard;
    guard = 0;
    while (t != target && guard < 60000) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (t != target) begin
      n_vec  = n_vec + 1;
      n_fail = n_fail + 1;
      $display("FAIL wait_to timeout: t=%0d, expected %0d", t, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htiming"},     32'(htiming),     32'd0);
    check({tag, "_vcount"},      32'(vcount),      32'd0);
    check({tag, "_vtiming_f"},   32'(vtiming_f),   32'h00);
    check({tag, "_hblank"},      32'(hblank),      32'd0);
    check({tag, "_vblank"},      32'(vblank),      32'd1);
    check({tag, "_cmpblk"},      32'(cmpblk),      32'd1);
    check({tag, "_hsync_n"},     32'(hsync_n),     32'd1);
    check({tag, "_vsync_n"},     32'(vsync_n),     32'd1);
    check({tag, "_vblk_start"},  32'(vblk_start),  32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd1);
    check({tag, "_nmi_n"},       32'(nmi_n),       32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    flip_ena = 1'b0;
    nmi_mask = 1'b0;
    nmi_ack  = 1'b0;
    #3;
    check_reset_outputs("rst");
    #9 rst_n = 1'b1;           // released at t=12, first posedge at 15

    // ---- frame 0: line timing, mask off ----
    wait_to(511);  #1 check("h511_hblank", 32'(hblank), 32'd0);
    wait_to(513);  #1 check("h513_hsync_n", 32'(hsync_n), 32'd1);
    wait_to(514);  #1 check("h514_hsync_n", 32'(hsync_n), 32'd0);
                      check("h514_hblank", 32'(hblank), 32'd1);
    wait_to(517);  #1 check("h517_hsync_n", 32'(hsync_n), 32'd0);
    wait_to(518);  #1 check("h518_hsync_n", 32'(hsync_n), 32'd1);
    wait_to(519);  #1 check("h519_htiming", 32'(htiming), 32'd519);
    wait_to(520);  #1 check("wrap_htiming", 32'(htiming), 32'd0);
                      check("wrap_vcount", 32'(vcount), 32'd1);
    wait_to(1040); #1 check("line2_vblank", 32'(vblank), 32'd0);
    wait_to(6240); #1 check("vblk0_strobe", 32'(vblk_start), 32'd1);
                      check("vblk0_vblank", 32'(vblank), 32'd1);
    wait_to(6241); #1 check("vblk0_masked_nmi_n", 32'(nmi_n), 32'd1);
    wait_to(6760); #1 check("line13_vsync_n", 32'(vsync_n), 32'd0);
    wait_to(FR - 1); #1 check("pre_frame_fs", 32'(frame_start), 32'd0);
    wait_to(FR);   #1 check("frame1_fs", 32'(frame_start), 32'd1);
                      check("frame1_vcount", 32'(vcount), 32'd0);
    nmi_mask = 1'b1;

    // ---- frame 1: flip request mid-frame, NMI set ----
    wait_to(FR + 8 * H);  flip_ena = 1'b1;
    wait_to(FR + 9 * H);  #1 check("flip_pending_vtf", 32'(vtiming_f), 32'h09);
    wait_to(FR + 6240);   #1 check("vblk1_nmi_n_pre", 32'(nmi_n), 32'd1);
    wait_to(FR + 6241);   #1 check("vblk1_nmi_n", 32'(nmi_n), 32'd0);

    // ---- frame 2: flip active, NMI held, ack ----
    wait_to(2 * FR);          #1 check("flip_line0_vtf", 32'(vtiming_f), 32'hFF);
                                 check("nmi_held", 32'(nmi_n), 32'd0);
    wait_to(2 * FR + 5 * H);  #1 check("flip_line5_vtf", 32'(vtiming_f), 32'hFA);
    nmi_ack = 1'b1;
    @(negedge clk); nmi_ack = 1'b0;
    #1 check("ack_nmi_n", 32'(nmi_n), 32'd1);
    wait_to(2 * FR + 7 * H);  flip_ena = 1'b0;
    wait_to(2 * FR + 9 * H);  #1 check("flip_held_vtf", 32'(vtiming_f), 32'hF6);

    // ---- frame 3: flip released, ack coincident with vblk_start ----
    wait_to(3 * FR);          #1 check("unflip_vtf", 32'(vtiming_f), 32'h00);
    wait_to(3 * FR + 100);    nmi_ack = 1'b1;   // clear the pend left by frame 2
    @(negedge clk); nmi_ack = 1'b0;
    wait_to(3 * FR + 6240);   #1 check("coinc_nmi_n_pre", 32'(nmi_n), 32'd1);
    nmi_ack = 1'b1;
    @(negedge clk); nmi_ack = 1'b0;
    #1 check("coinc_nmi_n", 32'(nmi_n), 32'd1);

    // ---- frame 4: mask drop while pending ----
    wait_to(4 * FR + 6241);   #1 check("vblk4_nmi_n", 32'(nmi_n), 32'd0);
    wait_to(4 * FR + 7000);   nmi_mask = 1'b0;
    @(negedge clk); #1 check("mask_drop_nmi_n", 32'(nmi_n), 32'd1);

    // ---- frame 5: async reset mid-line with flip and NMI active ----
    nmi_mask = 1'b1;
    flip_ena = 1'b1;
    wait_to(5 * FR + 10 * H + 300);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1 check("post_rst_htiming", 32'(htiming), 32'd1);
                       check("post_rst_vcount", 32'(vcount), 32'd0);
    wait_to(600);   #1 check("post_rst_line1", 32'(vcount), 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator that sits directly upstream of the tile and sprite generators.
- Produces the half-pixel horizontal counter `htiming`, the flip-adjusted vertical line index `vtiming_f`, the composite blank `cmpblk`, and the sync outputs.
- Also raises the CPU vertical-blank NMI request, with mask and acknowledge handshakes.
- Every video stage consumes its counters directly; no stage keeps a private raster count.

Parameters:
- H_TOTAL, 768: half-pixel clocks per line (384 pixels). Must be even and in 514..1024.
- V_TOTAL, 264: lines per frame. Must be ≤ 512.
- V_ACT_START, 16: first visible line.
- V_ACT_END, 240: first blanked line after the visible area. Vblank starts here.
- HS_START, 576: first `htiming` value with hsync asserted.
- HS_END, 640: first `htiming` value after hsync.
- VS_START, 244: first line with vsync asserted.
- VS_END, 248: first line after vsync.

Ports:
- clk, in, 1: half-pixel clock. All state updates on the rising edge.
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- flip_ena, in, 1: screen flip request from vidctrl.
- nmi_mask, in, 1: NMI enable from the CPU latch. 1 = enabled.
- nmi_ack, in, 1: one-clk acknowledge from the CPU interrupt-acknowledge decode.
- htiming, out, 10: horizontal counter, 0..H_TOTAL-1. `htiming[9]`=1 means hblank.
- vcount, out, 9: raw line counter, 0..V_TOTAL-1.
- vtiming_f, out, 8: `vcount[7:0] ^ {8{flip_q}}`.
- flip_q, out, 1: frame-synchronised flip.
- hblank, out, 1: `htiming[9]`.
- vblank, out, 1: 1 when vcount < V_ACT_START or vcount ≥ V_ACT_END.
- cmpblk, out, 1: hblank | vblank.
- hsync_n, out, 1: 0 when HS_START ≤ htiming < HS_END.
- vsync_n, out, 1: 0 when VS_START ≤ vcount < VS_END.
- vblk_start, out, 1: one-clk strobe when vcount == V_ACT_END and htiming == 0.
- frame_start, out, 1: one-clk strobe when vcount == 0 and htiming == 0.
- nmi_n, out, 1: level NMI request to the CPU. Active-low.

Behaviour:
- Registered state:
  - Horizontal counter `htiming` (10 bit).
  - Vertical counter `vcount` (9 bit).
  - `flip_q`.
  - NMI latch `nmi_pend`.
- All other outputs are combinational decodes of the registered state; no extra latency.
- Reset (`rst_n`=0, asynchronous):
  - htiming=0, vcount=0, flip_q=0, nmi_pend=0.
  - Resulting outputs: vtiming_f=0x00, hblank=0, vblank=1, cmpblk=1, hsync_n=1, vsync_n=1, vblk_start=0, frame_start=1, nmi_n=1.
- Horizontal count:
  - htiming increments by 1 every clk.
  - At H_TOTAL-1 it wraps to 0 and that same edge advances vcount.
- Vertical count:
  - vcount wraps from V_TOTAL-1 to 0 on the edge where htiming wraps.
  - vcount never changes mid-line.
- Line/pixel meaning: htiming 0..511 is the active line (256 pixels × 2 half-pixels); 512..H_TOTAL-1 is hblank.
- Flip:
  - flip_q samples flip_ena only on the edge entering vcount=0, htiming=0.
  - This is the same edge where frame_start becomes 1.
  - A mid-frame change of flip_ena has no effect until the next frame.
  - vtiming_f follows flip_q combinationally.
- NMI latch:
  - Set when vblk_start=1 and nmi_mask=1.
  - Cleared when nmi_ack=1 or nmi_mask=0.
  - Clear has priority over set in the same cycle.
  - nmi_n = ~nmi_pend.
  - The latch holds across lines and frames until cleared; a second vblk_start while pending keeps it set.
- Async reset mid-line or mid-frame returns immediately to the reset state. Counting resumes from 0/0 on the first clk after release.
- Widths: counters never exceed their TOTAL-1; there are no out-of-range states. The comparisons use unsigned full-width values.

Test Plan:
- Reset release, free-run 1 line:
  - htiming steps 0→767 then back to 0.
  - vcount goes 0→1 on that wrap edge.
  - hblank=1 exactly for htiming 512..767.
  - hsync_n=0 exactly for htiming 576..639.
- Free-run 1 full frame (202752 clks):
  - vblank=0 only for lines 16..239.
  - vsync_n=0 only for lines 244..247.
  - frame_start pulses twice, 202752 clks apart.
  - vblk_start pulses once, at line 240, htiming 0.
- Flip:
  - Drive flip_ena=1 at line 100.
  - vtiming_f stays equal to vcount[7:0] until the frame wraps.
  - At line 0 after the wrap, vtiming_f=0xFF; at line 5, 0xFA.
  - Drop flip_ena mid-frame: vtiming_f remains inverted until the next frame_start.
- NMI with nmi_mask=1:
  - nmi_n falls on the clk after the vblk_start edge.
  - It stays 0 into the next frame if no ack arrives.
  - A one-clk nmi_ack returns nmi_n to 1 the next clk.
  - With nmi_mask=0, nmi_n stays 1 through vblk_start.
- Simultaneous events:
  - nmi_ack=1 in the same cycle as vblk_start: nmi_n stays 1.
  - nmi_mask falling while pending: nmi_n returns to 1 the next clk.
- Async reset:
  - Assert rst_n at line 150, htiming 300, between clk edges.
  - Outputs reach reset values without a clk edge.
  - After release, the first clk gives htiming=1, vcount=0.
